// File: rtl/demux_scan_7ch.sv
// rtl/demux_scan_7ch.sv - round-robin select scanner that rebuilds 7 mux inputs into a parallel word
//
// Drives the 3-bit select code of an 8-to-1 mux through slots 0..7, samples the
// mux output once per slot and publishes the seven data bits at slot 7.
//
// Parameters:
//   SETTLE  en ticks per slot (1..15); d_in is sampled on the last tick of a slot
//   TW      tick counter width, 2**TW > SETTLE
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          scan tick; state advances only when high
//   d_in        serial bit from the mux output
//   b0,b1,b2    select code to the mux (b0 = MSB)
//   q[6:0]      last completed frame, q[k] = e_k
//   valid       set once the first frame has been published
//   frame_done  one-cycle pulse coinciding with a new q
//   sync_err    one-cycle pulse when slot 7 reads back 1 (SLOT7_CHECK_EN only)
//
// Build option: define SLOT7_CHECK_EN to reject frames whose slot-7 sample is 1.

module demux_scan_7ch #(
    parameter int SETTLE = 1,
    parameter int TW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       d_in,
    output logic       b0,
    output logic       b1,
    output logic       b2,
    output logic [6:0] q,
    output logic       valid,
    output logic       frame_done,
    output logic       sync_err
);

    // The slot counter is the state register; state is a decode of it.
    typedef enum logic {
        SCAN    = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      slot;
    logic [2:0]      slot_nx;
    logic [TW-1:0]   tick;
    logic [TW-1:0]   tick_nx;
    logic [6:0]      shadow;
    logic [6:0]      shadow_nx;
    logic [6:0]      q_nx;
    logic            valid_nx;
    logic            frame_done_nx;
    logic            sync_err_nx;
    logic            last_tick;

    assign b0 = slot[2];
    assign b1 = slot[1];
    assign b2 = slot[0];

    assign state     = (slot == 3'd7) ? PUBLISH : SCAN;
    assign last_tick = en && (tick == TW'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= 3'd0;
            tick       <= '0;
            shadow     <= 7'd0;
            q          <= 7'd0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            slot       <= slot_nx;
            tick       <= tick_nx;
            shadow     <= shadow_nx;
            q          <= q_nx;
            valid      <= valid_nx;
            frame_done <= frame_done_nx;
            sync_err   <= sync_err_nx;
        end
    end

    always_comb begin
        slot_nx       = slot;
        tick_nx       = tick;
        shadow_nx     = shadow;
        q_nx          = q;
        valid_nx      = valid;
        frame_done_nx = 1'b0;
        sync_err_nx   = 1'b0;

        if (en) begin
            tick_nx = tick + TW'(1);
        end

        if (last_tick) begin
            tick_nx = '0;
            slot_nx = slot + 3'd1;
            unique case (state)
                SCAN: begin
                    for (int k = 0; k < 7; k++) begin
                        if (slot == 3'(k)) begin
                            shadow_nx[k] = d_in;
                        end
                    end
                end
                PUBLISH: begin
                    // Shadow is not cleared: every bit is rewritten next frame.
`ifdef SLOT7_CHECK_EN
                    if (d_in) begin
                        sync_err_nx = 1'b1;
                    end else begin
                        q_nx          = shadow;
                        valid_nx      = 1'b1;
                        frame_done_nx = 1'b1;
                    end
`else
                    q_nx          = shadow;
                    valid_nx      = 1'b1;
                    frame_done_nx = 1'b1;
`endif
                end
                default: begin
                    slot_nx = slot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scan_7ch.sv
// tb/tb_demux_scan_7ch.sv - scoreboard bench for demux_scan_7ch (SETTLE=1 and SETTLE=3 instances)

module tb_demux_scan_7ch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic d_in = 1'b0;

    logic       b0_1, b1_1, b2_1, valid_1, fd_1, se_1;
    logic [6:0] q_1;
    logic       b0_3, b1_3, b2_3, valid_3, fd_3, se_3;
    logic [6:0] q_3;

    int tests = 0;
    int fails = 0;
    int cur = 1;
    logic [6:0] last_q = 7'd0;
    logic [6:0] q_exp[$];

    logic [2:0] sel_c;
    logic [6:0] q_c;
    logic       valid_c, fd_c, se_c;

    always #5 clk = ~clk;

    demux_scan_7ch #(.SETTLE(1), .TW(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .d_in(d_in),
        .b0(b0_1), .b1(b1_1), .b2(b2_1), .q(q_1),
        .valid(valid_1), .frame_done(fd_1), .sync_err(se_1)
    );

    demux_scan_7ch #(.SETTLE(3), .TW(4)) u3 (
        .clk(clk), .rst(rst), .en(en), .d_in(d_in),
        .b0(b0_3), .b1(b1_3), .b2(b2_3), .q(q_3),
        .valid(valid_3), .frame_done(fd_3), .sync_err(se_3)
    );

    always_comb begin
        if (cur == 1) begin
            sel_c = {b0_1, b1_1, b2_1};
            q_c = q_1; valid_c = valid_1; fd_c = fd_1; se_c = se_1;
        end else begin
            sel_c = {b0_3, b1_3, b2_3};
            q_c = q_3; valid_c = valid_3; fd_c = fd_3; se_c = se_3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic d, input logic efd, input logic ese);
        en = e;
        d_in = d;
        @(posedge clk);
        #1;
        chk("frame_done", 32'(fd_c), 32'(efd));
        chk("sync_err", 32'(se_c), 32'(ese));
        if (fd_c) begin
            if (q_exp.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_empty: observed publish of %0h expected none", q_c);
            end else begin
                chk("q_publish", 32'(q_c), 32'(q_exp.pop_front()));
            end
            chk("valid", 32'(valid_c), 32'd1);
        end else begin
            chk("q_hold", 32'(q_c), 32'(last_q));
        end
        last_q = q_c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q1", 32'(q_1), 32'd0);
        chk("rst_q3", 32'(q_3), 32'd0);
        chk("rst_valid", 32'({valid_1, valid_3}), 32'd0);
        chk("rst_sel", 32'({b0_1, b1_1, b2_1, b0_3, b1_3, b2_3}), 32'd0);
        chk("rst_pulses", 32'({fd_1, se_1, fd_3, se_3}), 32'd0);
        rst = 1'b0;
        en = 1'b0;
        last_q = 7'd0;
        q_exp.delete();
    endtask

    // Drives nslots slots of word w; non-sampling ticks carry the inverted bit.
    task automatic drive_frame(input logic [6:0] w, input logic s7, input bit stall, input int nslots);
        bit pub;
        pub = 1'b1;
`ifdef SLOT7_CHECK_EN
        if (s7) pub = 1'b0;
`endif
        if (nslots == 8 && pub) q_exp.push_back(w);
        for (int s = 0; s < nslots; s++) begin
            for (int t = 0; t < cur; t++) begin
                logic dv;
                logic last;
                last = (t == cur - 1);
                if (s < 7) dv = last ? w[s] : ~w[s];
                else       dv = last ? s7 : 1'b1;
                chk("sel", 32'(sel_c), 32'(s));
                if (stall) begin
                    step(1'b0, ~dv, 1'b0, 1'b0);
                    chk("sel_hold", 32'(sel_c), 32'(s));
                end
                step(1'b1, dv, last && s == 7 && pub, last && s == 7 && !pub);
            end
        end
    endtask

    initial begin
        cur = 1;
        do_reset();

        drive_frame(7'b1010011, 1'b0, 1'b0, 8);
        chk("basic_q", 32'(q_1), 32'h53);
        chk("sel_wrap", 32'(sel_c), 32'd0);

`ifdef SLOT7_CHECK_EN
        drive_frame(7'b1111111, 1'b1, 1'b0, 8);
        chk("err_q_kept", 32'(q_1), 32'h53);
        drive_frame(7'b0001111, 1'b0, 1'b0, 8);
        chk("after_err_q", 32'(q_1), 32'h0F);
`endif

        drive_frame(7'b1010101, 1'b0, 1'b0, 8);
        chk("b2b_55", 32'(q_1), 32'h55);
        drive_frame(7'b0101010, 1'b0, 1'b0, 8);
        chk("b2b_2a", 32'(q_1), 32'h2A);

        cur = 3;
        do_reset();
        drive_frame(7'b1100110, 1'b0, 1'b1, 8);
        chk("settle_q", 32'(q_3), 32'h66);
        chk("settle_valid", 32'(valid_3), 32'd1);

        do_reset();
        drive_frame(7'b1111111, 1'b0, 1'b0, 4);
        chk("mid_sel4", 32'(sel_c), 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        drive_frame(7'b0011001, 1'b0, 1'b0, 8);
        chk("mid_q", 32'(q_3), 32'h19);
        drive_frame(7'b1000001, 1'b0, 1'b1, 8);
        chk("stall2_q", 32'(q_3), 32'h41);

        chk("sb_drained", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
